cla_pipe_addsub: RTL and testbench

CLA_PIPE_ADDSUB -- requirements
Module: cla_pipe_addsub

---
 rtl/cla_pipe_addsub_if.sv | 28 ++
 rtl/cla_pipe_addsub.sv | 98 +++++++++
 tb/tb_cla_pipe_addsub.sv | 317 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cla_pipe_addsub_if.sv
// Handshake and operand/result bundle for the pipelined carry-lookahead adder/subtractor.
// The master drives operands and result-ready; the slave (the adder) returns results.
interface cla_pipe_addsub_if #(
    parameter int unsigned WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] da;
    logic [WIDTH-1:0] db;
    logic             cin;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             c_out;
    logic             ovf;
    logic             zero;

    modport master (
        output in_valid, da, db, cin, sub, out_ready,
        input  in_ready, out_valid, sum, c_out, ovf, zero
    );

    modport slave (
        input  in_valid, da, db, cin, sub, out_ready,
        output in_ready, out_valid, sum, c_out, ovf, zero
    );
endinterface

// File: rtl/cla_pipe_addsub.sv
// Pipelined add/subtract: one BLOCK-wide carry-lookahead group resolved per stage,
// behind an operand capture register, so latency is WIDTH/BLOCK cycles.
module cla_pipe_addsub #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned BLOCK = 4
) (
    input logic            clk,
    input logic            rst,
    cla_pipe_addsub_if.slave bus_io
);
    localparam int unsigned NSTG = WIDTH / BLOCK;

    logic                             adv;
    logic [NSTG:0]                    v_q;
    logic [NSTG-1:0][WIDTH-1:0]       a_q;
    logic [NSTG-1:0][WIDTH-1:0]       b_q;
    logic [NSTG-1:0][WIDTH-1:0]       s_q;
    logic [NSTG-1:0][WIDTH-1:0]       s_d;
    logic [NSTG:0]                    c_q;
    logic [NSTG-1:0]                  cy_d;
    logic                             ovf_q, ovf_d;
    logic                             zero_q, zero_d;
    logic                             unused_ops;

    // Whole pipeline moves together; it only stalls when a result is held at the output.
    assign adv = ~v_q[NSTG] | bus_io.out_ready;

    // Stage k reads operand bank k and carry c_q[k]; writes group k of the sum.
    for (genvar k = 0; k < NSTG; k++) begin : g_stg
        logic [BLOCK-1:0] p;
        logic [BLOCK-1:0] g;
        logic [BLOCK:0]   c;
        logic [WIDTH-1:0] s_prev;
        logic [WIDTH-1:0] s_new;

        assign p = a_q[k][k*BLOCK +: BLOCK] ^ b_q[k][k*BLOCK +: BLOCK];
        assign g = a_q[k][k*BLOCK +: BLOCK] & b_q[k][k*BLOCK +: BLOCK];

        if (k == 0) begin : g_first
            assign s_prev = '0;
        end else begin : g_rest
            assign s_prev = s_q[k-1];
        end

        always_comb begin
            c[0]  = c_q[k];
            s_new = s_prev;
            for (int i = 0; i < int'(BLOCK); i++) begin
                s_new[k*BLOCK + i] = p[i] ^ c[i];
                c[i+1]             = g[i] | (p[i] & c[i]);
            end
        end

        assign s_d[k]  = s_new;
        assign cy_d[k] = c[BLOCK];

        if (k == NSTG - 1) begin : g_last
            assign ovf_d = c[BLOCK] ^ c[BLOCK-1];
        end
    end

    assign zero_d = ~|s_d[NSTG-1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v_q    <= '0;
            a_q    <= '0;
            b_q    <= '0;
            s_q    <= '0;
            c_q    <= '0;
            ovf_q  <= 1'b0;
            zero_q <= 1'b0;
        end else if (adv) begin
            v_q    <= {v_q[NSTG-1:0], bus_io.in_valid};
            a_q[0] <= bus_io.da;
            b_q[0] <= bus_io.sub ? ~bus_io.db : bus_io.db;
            c_q[0] <= bus_io.sub | bus_io.cin;
            for (int j = 1; j < int'(NSTG); j++) begin
                a_q[j] <= a_q[j-1];
                b_q[j] <= b_q[j-1];
            end
            s_q         <= s_d;
            c_q[NSTG:1] <= cy_d;
            ovf_q       <= ovf_d;
            zero_q      <= zero_d;
        end
    end

    // Bits of already-resolved groups in the last operand bank are dead by construction.
    assign unused_ops = ^{a_q[NSTG-1], b_q[NSTG-1]};

    assign bus_io.in_ready  = adv;
    assign bus_io.out_valid = v_q[NSTG];
    assign bus_io.sum       = s_q[NSTG-1];
    assign bus_io.c_out     = c_q[NSTG];
    assign bus_io.ovf       = ovf_q;
    assign bus_io.zero      = zero_q;
endmodule

// File: tb/tb_cla_pipe_addsub.sv
// Bench for cla_pipe_addsub: directed literal vectors, back-to-back and backpressure runs,
// async reset with beats in flight, and a 4/4, 8/4, 32/8 parameter sweep against a model.
module tb_cla_pipe_addsub;
    logic clk;
    logic rst;
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_err = 0;
    bit   no_bp = 1'b1;

    typedef struct {
        logic [31:0] sum;
        logic        c;
        logic        v;
        logic        z;
        int          acc;
        bit          lat;
    } exp_t;

    exp_t q [4][$];
    bit   hold [4];
    bit   seen [4];

    cla_pipe_addsub_if #(.WIDTH(16)) bus   ();
    cla_pipe_addsub_if #(.WIDTH(4))  bus4  ();
    cla_pipe_addsub_if #(.WIDTH(8))  bus8  ();
    cla_pipe_addsub_if #(.WIDTH(32)) bus32 ();

    cla_pipe_addsub #(.WIDTH(16), .BLOCK(4)) u_dut16 (.clk(clk), .rst(rst), .bus_io(bus));
    cla_pipe_addsub #(.WIDTH(4),  .BLOCK(4)) u_dut4  (.clk(clk), .rst(rst), .bus_io(bus4));
    cla_pipe_addsub #(.WIDTH(8),  .BLOCK(4)) u_dut8  (.clk(clk), .rst(rst), .bus_io(bus8));
    cla_pipe_addsub #(.WIDTH(32), .BLOCK(8)) u_dut32 (.clk(clk), .rst(rst), .bus_io(bus32));

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    // Plain modular arithmetic; overflow from operand/result signs.
    function automatic exp_t model(input int w, input logic [31:0] a, input logic [31:0] b,
                                   input logic cin, input logic sub, input int acc);
        logic [63:0] mask, aa, bb, t, sm;
        exp_t        e;
        mask  = (64'd1 << w) - 64'd1;
        aa    = {32'd0, a} & mask;
        bb    = sub ? (~{32'd0, b}) & mask : {32'd0, b} & mask;
        t     = aa + bb + (sub ? 64'd1 : {63'd0, cin});
        sm    = t & mask;
        e.sum = sm[31:0];
        e.c   = t[w];
        e.z   = (sm == 64'd0);
        e.v   = (aa[w-1] == bb[w-1]) && (sm[w-1] != aa[w-1]);
        e.acc = acc;
        e.lat = no_bp;
        return e;
    endfunction

    task automatic port(input int d, input string nm, input int nstg, input logic ov,
                        input logic ordy, input logic [31:0] s, input logic c, input logic v,
                        input logic z);
        exp_t e;
        if (hold[d]) cmp({nm, " stalled out_valid"}, 32'(ov), 32'd1);
        hold[d] = ov && !ordy;
        if (ov) begin
            if (q[d].size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL %s spurious: got out_valid=1, expected no beat outstanding", nm);
            end else begin
                e = q[d][0];
                cmp({nm, " sum"},   s,         e.sum);
                cmp({nm, " c_out"}, 32'(c),    32'(e.c));
                cmp({nm, " ovf"},   32'(v),    32'(e.v));
                cmp({nm, " zero"},  32'(z),    32'(e.z));
                if (e.lat && !seen[d]) cmp({nm, " latency"}, 32'(cyc - e.acc), 32'(nstg));
                seen[d] = 1'b1;
                if (ordy) begin
                    void'(q[d].pop_front());
                    seen[d] = 1'b0;
                end
            end
        end
    endtask

    always @(negedge clk) begin
        if (rst) begin
            for (int d = 0; d < 4; d++) begin
                q[d].delete();
                hold[d] = 1'b0;
                seen[d] = 1'b0;
            end
        end else begin
            if (bus.in_valid && bus.in_ready)
                q[0].push_back(model(16, 32'(bus.da), 32'(bus.db), bus.cin, bus.sub, cyc + 1));
            if (bus4.in_valid && bus4.in_ready)
                q[1].push_back(model(4, 32'(bus4.da), 32'(bus4.db), bus4.cin, bus4.sub, cyc + 1));
            if (bus8.in_valid && bus8.in_ready)
                q[2].push_back(model(8, 32'(bus8.da), 32'(bus8.db), bus8.cin, bus8.sub, cyc + 1));
            if (bus32.in_valid && bus32.in_ready)
                q[3].push_back(model(32, bus32.da, bus32.db, bus32.cin, bus32.sub, cyc + 1));
            port(0, "w16", 4, bus.out_valid, bus.out_ready, 32'(bus.sum), bus.c_out, bus.ovf,
                 bus.zero);
            port(1, "w4", 1, bus4.out_valid, bus4.out_ready, 32'(bus4.sum), bus4.c_out,
                 bus4.ovf, bus4.zero);
            port(2, "w8", 2, bus8.out_valid, bus8.out_ready, 32'(bus8.sum), bus8.c_out,
                 bus8.ovf, bus8.zero);
            port(3, "w32", 4, bus32.out_valid, bus32.out_ready, bus32.sum, bus32.c_out,
                 bus32.ovf, bus32.zero);
        end
    end

    task automatic wait_out(output int n);
        n = 0;
        while (!bus.out_valid && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
    endtask

    task automatic drain(input int d);
        int n;
        n = 0;
        while (q[d].size() != 0 && n < 200) begin
            @(posedge clk);
            n++;
        end
        cmp($sformatf("drain port %0d outstanding", d), 32'(q[d].size()), 32'd0);
    endtask

    task automatic directed(input string nm, input logic [15:0] a, input logic [15:0] b,
                            input logic ci, input logic sb, input logic [15:0] es,
                            input logic ec, input logic ev, input logic ez);
        int n;
        @(posedge clk);
        #1;
        bus.da       = a;
        bus.db       = b;
        bus.cin      = ci;
        bus.sub      = sb;
        bus.in_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        wait_out(n);
        cmp({nm, " latency"}, 32'(n), 32'd4);
        cmp({nm, " sum"},     32'(bus.sum), 32'(es));
        cmp({nm, " c_out"},   32'(bus.c_out), 32'(ec));
        cmp({nm, " ovf"},     32'(bus.ovf), 32'(ev));
        cmp({nm, " zero"},    32'(bus.zero), 32'(ez));
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation still running at %0t, expected $finish", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] r;
        logic [9:0]  v;
        int          n;
        bit          hold_in;
        bit          acc_now;

        rst = 1'b1;
        bus.in_valid = 1'b0;  bus.out_ready = 1'b1;  bus.da = '0;  bus.db = '0;
        bus.cin = 1'b0;       bus.sub = 1'b0;
        bus4.in_valid = 1'b0; bus4.out_ready = 1'b1; bus4.da = '0; bus4.db = '0;
        bus4.cin = 1'b0;      bus4.sub = 1'b0;
        bus8.in_valid = 1'b0; bus8.out_ready = 1'b1; bus8.da = '0; bus8.db = '0;
        bus8.cin = 1'b0;      bus8.sub = 1'b0;
        bus32.in_valid = 1'b0; bus32.out_ready = 1'b1; bus32.da = '0; bus32.db = '0;
        bus32.cin = 1'b0;      bus32.sub = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        cmp("reset out_valid", 32'(bus.out_valid), 32'd0);
        cmp("reset sum",       32'(bus.sum), 32'd0);
        cmp("reset c_out",     32'(bus.c_out), 32'd0);
        cmp("reset ovf",       32'(bus.ovf), 32'd0);
        cmp("reset zero",      32'(bus.zero), 32'd0);
        cmp("reset in_ready",  32'(bus.in_ready), 32'd1);
        #2 rst = 1'b0;

        directed("ffff+1",     16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1);
        directed("7fff+1",     16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0);
        directed("3-5",        16'h0003, 16'h0005, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0, 1'b0);
        directed("8000-1",     16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1, 1'b0);
        directed("1234+4321c", 16'h1234, 16'h4321, 1'b1, 1'b0, 16'h5556, 1'b0, 1'b0, 1'b0);
        directed("5-5 cin1",   16'h0005, 16'h0005, 1'b1, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b1);
        directed("ffff+ffffc", 16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 16'hFFFF, 1'b1, 1'b0, 1'b0);

        // Back-to-back stream, no backpressure.
        @(posedge clk);
        #1;
        for (int i = 0; i < 100; i++) begin
            r = $urandom;
            bus.da = r[15:0];
            bus.db = r[31:16];
            r = $urandom;
            bus.cin = r[0];
            bus.sub = r[1];
            bus.in_valid = 1'b1;
            @(posedge clk);
            #1;
        end
        bus.in_valid = 1'b0;
        drain(0);

        // Random valid/ready; an offered beat is held until it is taken.
        no_bp = 1'b0;
        hold_in = 1'b0;
        @(posedge clk);
        #1;
        repeat (300) begin
            r = $urandom;
            bus.out_ready = r[0];
            if (!hold_in) begin
                bus.in_valid = r[1];
                bus.cin      = r[2];
                bus.sub      = r[3];
                r = $urandom;
                bus.da = r[15:0];
                bus.db = r[31:16];
            end
            #1;
            acc_now = bus.in_valid && bus.in_ready;
            @(posedge clk);
            #1;
            hold_in = bus.in_valid && !acc_now;
        end
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        drain(0);
        no_bp = 1'b1;

        // Async reset with five beats in flight, the oldest already at the output.
        @(posedge clk);
        #1;
        for (int i = 0; i < 5; i++) begin
            bus.da = 16'(i * 16'h0101);
            bus.db = 16'h0011;
            bus.cin = 1'b0;
            bus.sub = 1'b0;
            bus.in_valid = 1'b1;
            @(posedge clk);
            #1;
        end
        bus.in_valid = 1'b0;
        cmp("pre-reset out_valid", 32'(bus.out_valid), 32'd1);
        #1 rst = 1'b1;
        #1;
        cmp("async rst out_valid", 32'(bus.out_valid), 32'd0);
        cmp("async rst sum",       32'(bus.sum), 32'd0);
        cmp("async rst c_out",     32'(bus.c_out), 32'd0);
        cmp("async rst zero",      32'(bus.zero), 32'd0);
        cmp("async rst in_ready",  32'(bus.in_ready), 32'd1);
        bus.da = 16'h8000;
        bus.db = 16'h0001;
        bus.sub = 1'b1;
        bus.in_valid = 1'b1;
        repeat (2) @(posedge clk);
        #3 rst = 1'b0;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        wait_out(n);
        cmp("post-rst latency", 32'(n), 32'd4);
        cmp("post-rst sum",     32'(bus.sum), 32'h7FFF);
        cmp("post-rst ovf",     32'(bus.ovf), 32'd1);
        cmp("post-rst c_out",   32'(bus.c_out), 32'd1);
        drain(0);

        // Parameter sweep: exhaustive 4/4 (a, b, cin, sub), random 8/4 and 32/8.
        @(posedge clk);
        #1;
        for (int i = 0; i < 1024; i++) begin
            v = i[9:0];
            bus4.da = v[3:0];
            bus4.db = v[7:4];
            bus4.cin = v[8];
            bus4.sub = v[9];
            bus4.in_valid = 1'b1;
            r = $urandom;
            bus8.da = r[7:0];
            bus8.db = r[15:8];
            bus8.cin = r[16];
            bus8.sub = r[17];
            bus8.in_valid = 1'b1;
            bus32.da = $urandom;
            bus32.db = $urandom;
            r = $urandom;
            bus32.cin = r[0];
            bus32.sub = r[1];
            bus32.in_valid = 1'b1;
            @(posedge clk);
            #1;
        end
        bus4.in_valid = 1'b0;
        bus8.in_valid = 1'b0;
        bus32.in_valid = 1'b0;
        drain(1);
        drain(2);
        drain(3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
